axi_lite_read_arbiter: RTL
==========================

AXI_LITE_READ_ARBITER -- requirements
Module: axi_lite_read_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting AXI4-Lite read masters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, read-address width.
REQ-003 Parameter DATA_WIDTH, default 32, read-data width.
REQ-004 ACLK  input  1  single clock; all state updates on its rising edge.
REQ-005 ARESETn  input  1  synchronous, active-high reset; when 1 at a rising ACLK edge, the block resets.
REQ-006 S_ARVALID  input  NUM_MASTERS  per-master read-address valid.
REQ-007 S_ARREADY  output  NUM_MASTERS  per-master read-address ready.
REQ-008 S_ARADDR  input  NUM_MASTERS*ADDR_WIDTH  packed per-master addresses; master i occupies slice i.
REQ-009 S_ARPROT  input  NUM_MASTERS*3  packed per-master protection bits.
REQ-010 S_RVALID  output  NUM_MASTERS  per-master read-data valid.
REQ-011 S_RREADY  input  NUM_MASTERS  per-master read-data ready.
REQ-012 S_RDATA  output  DATA_WIDTH  read data, broadcast to all masters.
REQ-013 S_RRESP  output  2  read response, broadcast to all masters.
REQ-014 M_ARVALID / M_ARREADY  output / input  1 / 1  shared slave address handshake.
REQ-015 M_ARADDR / M_ARPROT  output  ADDR_WIDTH / 3  shared slave address and protection.
REQ-016 M_RVALID / M_RREADY  input / output  1 / 1  shared slave data handshake.
REQ-017 M_RDATA / M_RRESP  input  DATA_WIDTH / 2  shared slave data and response.
REQ-018 GRANT_ID  output  clog2(NUM_MASTERS)  index of the master currently owning the channel.
REQ-019 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ADDR, DATA; only one read is outstanding at any time.
REQ-021 IDLE: when any S_ARVALID is high, the round-robin winner g SHALL be chosen; in that same cycle S_ARREADY[g]=1 for exactly one cycle; S_ARADDR/S_ARPROT slice g and g are registered; next state ADDR.
REQ-022 Round-robin: search starts at index RR_PTR and ascends with wrap-around from NUM_MASTERS-1 to 0; the first requester found wins.
REQ-023 ADDR: M_ARVALID=1 with registered M_ARADDR/M_ARPROT held stable until M_ARVALID&&M_ARREADY, then next state DATA; M_ARVALID is never withdrawn before the handshake.
REQ-024 DATA: M_RREADY=S_RREADY[g]; S_RVALID[g]=M_RVALID; all other S_RVALID bits 0; on M_RVALID&&M_RREADY, next state IDLE and RR_PTR=(g+1) mod NUM_MASTERS.
REQ-025 S_RDATA=M_RDATA and S_RRESP=M_RRESP combinationally in every state; SLVERR/DECERR pass through unchanged.
REQ-026 M_RREADY SHALL be 0 in IDLE and ADDR; an M_RVALID arriving before the address handshake is ignored.
REQ-027 S_ARREADY SHALL be 0 in ADDR and DATA; requests arriving then wait, then compete at the next IDLE cycle.
REQ-028 Latency: request-accept to M_ARVALID = 1 cycle; minimum back-to-back throughput = 1 read per 3 cycles (IDLE, ADDR, DATA).
REQ-029 GRANT_ID SHALL hold g from the cycle after acceptance until returning to IDLE, and keep the last value while in IDLE.

Reset
REQ-030 On reset: state IDLE, RR_PTR=0, GRANT_ID=0, M_ARVALID=0, M_ARADDR=0, M_ARPROT=0, S_ARREADY=0, S_RVALID=0, M_RREADY=0, BUSY=0.
REQ-031 Reset asserted in ADDR or DATA SHALL abandon the transaction with no completion to any master; reset dominates all other events in the same cycle.
REQ-032 S_ARREADY SHALL remain 0 in any cycle where ARESETn=1.

Verification
REQ-033 Single request: master 2 issues ARADDR=0x0000_1000, slave ARREADY immediate, RDATA=0xDEADBEEF -> M_ARADDR=0x1000 one cycle after accept, S_RVALID=4'b0100, data 0xDEADBEEF, BUSY low on the 4th cycle.
REQ-034 All four masters request continuously after reset -> grant order 0,1,2,3,0; each S_ARREADY pulses exactly once per grant.
REQ-035 Slave stalls M_ARREADY for 5 cycles -> M_ARVALID/M_ARADDR stable for 6 cycles; no S_ARREADY pulses meanwhile.
REQ-036 Granted master holds S_RREADY=0 for 3 cycles while M_RVALID=1, RRESP=2'b10 -> M_RREADY=0 for those cycles; completion carries RRESP=2'b10.
REQ-037 Reset asserted in DATA with M_RVALID=1 -> next cycle all outputs at reset values, RR_PTR=0, master 0 wins next arbitration.

Source files
------------

// File: rtl/axi_lite_read_arbiter.sv
// AXI4-Lite read-channel arbiter: NUM_MASTERS read masters share one slave.
// One read is outstanding at a time. The controller moves IDLE -> ADDR -> DATA.
// Masters are granted in round-robin order, starting after the last served master.
//
// Ports
//   ACLK, ARESETn                   clock; synchronous active-HIGH reset
//   S_AR* / S_R*                    per-master read-address and read-data channels
//                                   (address fields are packed, master i in slice i;
//                                   data and response are broadcast to all masters)
//   M_AR* / M_R*                    shared slave read-address and read-data channels
//   GRANT_ID                        index of the master that owns the channel
//   BUSY                            high while a read is in flight (state not IDLE)
module axi_lite_read_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_MASTERS-1:0]            S_ARVALID,
  output logic [NUM_MASTERS-1:0]            S_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [NUM_MASTERS*3-1:0]          S_ARPROT,
  output logic [NUM_MASTERS-1:0]            S_RVALID,
  input  logic [NUM_MASTERS-1:0]            S_RREADY,
  output logic [DATA_WIDTH-1:0]             S_RDATA,
  output logic [1:0]                        S_RRESP,
  output logic                              M_ARVALID,
  input  logic                              M_ARREADY,
  output logic [ADDR_WIDTH-1:0]             M_ARADDR,
  output logic [2:0]                        M_ARPROT,
  input  logic                              M_RVALID,
  output logic                              M_RREADY,
  input  logic [DATA_WIDTH-1:0]             M_RDATA,
  input  logic [1:0]                        M_RRESP,
  output logic [$clog2(NUM_MASTERS)-1:0]    GRANT_ID,
  output logic                              BUSY
);

  localparam int unsigned GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;

  logic [GW-1:0]         win;
  logic                  any_req;
  logic [GW-1:0]         cand;
  int unsigned           idx;
  logic [GW-1:0]         grant_next;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
  logic [2:0]            prot_arr [NUM_MASTERS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      addr_arr[i] = S_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      prot_arr[i] = S_ARPROT[i*3 +: 3];
    end
  end

  // Round-robin search: start at rr_ptr_q, go up, and wrap to 0.
  // The first requester found is the winner.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx  = (32'(rr_ptr_q) + i) % NUM_MASTERS;
      cand = GW'(idx);
      if (!any_req && S_ARVALID[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  assign grant_next = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arprot_d  = arprot_q;
    S_ARREADY = '0;
    S_RVALID  = '0;
    M_RREADY  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          // Reset takes priority: while reset is high, no address is accepted.
          S_ARREADY[win] = !ARESETn;
          grant_d        = win;
          araddr_d       = addr_arr[win];
          arprot_d       = prot_arr[win];
          state_d        = ADDR;
        end
      end
      ADDR: begin
        if (M_ARREADY) state_d = DATA;
      end
      DATA: begin
        // The data handshake is also blocked during reset. A read that is
        // cut off by reset is therefore never completed to any master.
        M_RREADY           = S_RREADY[grant_q] && !ARESETn;
        S_RVALID[grant_q]  = M_RVALID && !ARESETn;
        if (M_RVALID && S_RREADY[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      araddr_q <= '0;
      arprot_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
      arprot_q <= arprot_d;
    end
  end

  assign M_ARVALID = (state_q == ADDR);
  assign M_ARADDR  = araddr_q;
  assign M_ARPROT  = arprot_q;
  assign S_RDATA   = M_RDATA;
  assign S_RRESP   = M_RRESP;
  assign GRANT_ID  = grant_q;
  assign BUSY      = (state_q != IDLE);

endmodule
